// File: rtl/cam_pkg.sv
// Shared definitions for the camera capture path: FSM state encoding and
// the default stored-frame geometry.
package cam_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_DONE   = 2'd3
    } cam_state_t;

    localparam int CAM_H_PIX   = 160;
    localparam int CAM_V_LINES = 120;

endpackage

// File: rtl/sync_edge_det.sv
// One-register edge detector for a level input on the pixel clock: the
// registered copy is compared against the live input to form 1-cycle pulses.
module sync_edge_det (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic rise,
    output logic fall
);

    logic q;

    // NOTE: sequential state uses <= only, so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) q <= 1'b0;
        else       q <= d;
    end

    assign rise = d & ~q;
    assign fall = q & ~d;

endmodule

// File: rtl/frame_addr_gen.sv
// Frame-buffer write-address generator: follows vsync/href timing and issues
// one registered write strobe and address per kept pixel of an armed frame.
module frame_addr_gen
    import cam_pkg::*;
#(
    parameter int H_PIX   = CAM_H_PIX,
    parameter int V_LINES = CAM_V_LINES,
    parameter int AW      = 15,
    parameter int SUB_X   = 1,
    parameter int SUB_Y   = 1
) (
    input  logic          pclk,
    input  logic          in_reset,
    input  logic          start,
    input  logic          continuous,
    input  logic          vsync,
    input  logic          href,
    input  logic          px_valid,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic          busy,
    output logic          frame_done,
    output logic          err_line,
    output logic          err_frame
);

    localparam int COL_W  = $clog2(H_PIX + 1);
    localparam int LINE_W = $clog2(V_LINES + 1);
    localparam logic [COL_W-1:0]  H_MAX  = COL_W'(H_PIX);
    localparam logic [LINE_W-1:0] V_MAX  = LINE_W'(V_LINES);
    localparam logic [AW-1:0]     H_STEP = AW'(H_PIX);

    cam_state_t        state, state_next;
    logic              set_err_frame;
    logic              vs_rise, vs_fall, hr_rise, hr_fall;
    logic [COL_W-1:0]  col_cnt;
    logic [LINE_W-1:0] line_cnt;
    logic [AW-1:0]     line_base;
    logic              x_phase, y_phase, x_ph_cur;
    logic              line_keep, px_keep, px_cand, px_kept, px_take, px_over;
    logic              line_end, frame_enter;

    sync_edge_det u_vs_det (
        .clk   (pclk),
        .reset (in_reset),
        .d     (vsync),
        .rise  (vs_rise),
        .fall  (vs_fall)
    );

    sync_edge_det u_hr_det (
        .clk   (pclk),
        .reset (in_reset),
        .d     (href),
        .rise  (hr_rise),
        .fall  (hr_fall)
    );

    always_ff @(posedge pclk) begin
        if (in_reset) state <= ST_IDLE;
        else          state <= state_next;
    end

    // NOTE: defaults first so no path through this block can infer a latch.
    always_comb begin
        state_next    = state;
        set_err_frame = 1'b0;
        case (state)
            ST_IDLE:   if (start) state_next = ST_ARMED;
            ST_ARMED:  if (vs_fall) state_next = ST_ACTIVE;
            ST_ACTIVE: begin
                if (line_cnt == V_MAX) begin
                    state_next = ST_DONE;
                end else if (vs_rise) begin
                    state_next    = ST_DONE;
                    set_err_frame = 1'b1;
                end
            end
            ST_DONE:   state_next = continuous ? ST_ARMED : ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    assign busy       = (state == ST_ARMED) || (state == ST_ACTIVE);
    assign frame_done = (state == ST_DONE);

    // The x phase restarts on the very cycle href rises, so the first pixel
    // of a line is always kept.
    assign x_ph_cur    = hr_rise ? 1'b0 : x_phase;
    assign line_keep   = (SUB_Y == 1) || !y_phase;
    assign px_keep     = (SUB_X == 1) || !x_ph_cur;
    assign px_cand     = (state == ST_ACTIVE) && px_valid && href;
    assign px_kept     = px_cand && line_keep && px_keep && (state_next == ST_ACTIVE);
    assign px_take     = px_kept && (col_cnt < H_MAX);
    assign px_over     = px_kept && (col_cnt == H_MAX);
    assign line_end    = (state == ST_ACTIVE) && hr_fall;
    assign frame_enter = (state == ST_ARMED) && vs_fall;

    always_ff @(posedge pclk) begin
        if (in_reset) begin
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            err_line  <= 1'b0;
            err_frame <= 1'b0;
            col_cnt   <= '0;
            line_cnt  <= '0;
            line_base <= '0;
            x_phase   <= 1'b0;
            y_phase   <= 1'b0;
        end else begin
            wr_en <= px_take;
            if (px_take) wr_addr <= line_base + AW'(col_cnt);

            if ((state == ST_IDLE) && start) begin
                err_line  <= 1'b0;
                err_frame <= 1'b0;
            end
            if (set_err_frame) err_frame <= 1'b1;

            if (frame_enter) begin
                col_cnt   <= '0;
                line_cnt  <= '0;
                line_base <= '0;
                x_phase   <= 1'b0;
                y_phase   <= 1'b0;
            end else if (line_end) begin
                y_phase <= (SUB_Y == 2) ? ~y_phase : 1'b0;
                x_phase <= 1'b0;
                col_cnt <= '0;
                // Each kept line starts on its own H_PIX boundary, whatever
                // length the previous line turned out to be.
                if (line_keep) begin
                    if (col_cnt != H_MAX) err_line <= 1'b1;
                    line_base <= line_base + H_STEP;
                    line_cnt  <= line_cnt + 1'b1;
                end
            end else begin
                if (px_cand)      x_phase <= (SUB_X == 2) ? ~x_ph_cur : 1'b0;
                else if (hr_rise) x_phase <= 1'b0;
                if (px_take) col_cnt  <= col_cnt + 1'b1;
                if (px_over) err_line <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_frame_addr_gen.sv
// Directed bench for frame_addr_gen: a default-geometry instance plus a small
// 8x6 instance built with SUB_X=SUB_Y=2, both fed from the same stimulus.
module tb_frame_addr_gen;

    logic        pclk = 1'b0;
    logic        in_reset, start, continuous, vsync, href, px_valid;
    logic        wr_en, busy, frame_done, err_line, err_frame;
    logic [14:0] wr_addr;
    logic        s_wr_en, s_busy, s_frame_done, s_err_line, s_err_frame;
    logic [5:0]  s_wr_addr;

    int          vec_cnt = 0;
    int          err_cnt = 0;
    logic [14:0] wr_q[$];
    int          fd_cnt, lat_err, busy_gap, s_wr_cnt, s_fd_cnt;
    bit          lat_chk, busy_chk;

    always #5 pclk = ~pclk;

    frame_addr_gen dut (
        .pclk       (pclk),
        .in_reset   (in_reset),
        .start      (start),
        .continuous (continuous),
        .vsync      (vsync),
        .href       (href),
        .px_valid   (px_valid),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .busy       (busy),
        .frame_done (frame_done),
        .err_line   (err_line),
        .err_frame  (err_frame)
    );

    // Reduced geometry keeps the subsampled frame short: 16x12 in, 8x6 stored.
    frame_addr_gen #(.H_PIX(8), .V_LINES(6), .AW(6), .SUB_X(2), .SUB_Y(2)) dut_sub (
        .pclk       (pclk),
        .in_reset   (in_reset),
        .start      (start),
        .continuous (continuous),
        .vsync      (vsync),
        .href       (href),
        .px_valid   (px_valid),
        .wr_en      (s_wr_en),
        .wr_addr    (s_wr_addr),
        .busy       (s_busy),
        .frame_done (s_frame_done),
        .err_line   (s_err_line),
        .err_frame  (s_err_frame)
    );

    // One clock: inputs change 1 ns after the rising edge, outputs are read there too.
    task automatic step();
        logic pv;
        pv = px_valid;
        @(posedge pclk);
        #1;
        if (wr_en) wr_q.push_back(wr_addr);
        if (frame_done) fd_cnt++;
        if (lat_chk && (wr_en !== pv)) lat_err++;
        if (busy_chk && !busy && !frame_done) busy_gap++;
        if (s_wr_en) s_wr_cnt++;
        if (s_frame_done) s_fd_cnt++;
    endtask

    task automatic clear_mon();
        wr_q.delete();
        fd_cnt = 0; lat_err = 0; busy_gap = 0; s_wr_cnt = 0; s_fd_cnt = 0;
        lat_chk = 1'b0; busy_chk = 1'b0;
    endtask

    task automatic pulse_reset();
        in_reset = 1'b1; repeat (2) step();
        in_reset = 1'b0; step();
    endtask

    task automatic begin_frame();
        start = 1'b1; step();
        start = 1'b0;
        vsync = 1'b1; repeat (3) step();
        vsync = 1'b0; repeat (2) step();
    endtask

    task automatic send_line(input int n);
        href = 1'b1;
        for (int i = 0; i < n; i++) begin
            px_valid = 1'b1;
            step();
        end
        px_valid = 1'b0;
        href     = 1'b0;
        repeat (4) step();
    endtask

    task automatic end_frame_early();
        vsync = 1'b1;
        repeat (4) step();
    endtask

    task automatic test_reset();
        in_reset = 1'b1; start = 1'b1; vsync = 1'b1; href = 1'b1; px_valid = 1'b1;
        repeat (3) step();
        vec_cnt++; if (wr_en !== 1'b0) begin err_cnt++; $display("FAIL rst_wr_en got %b want 0", wr_en); end
        vec_cnt++; if (wr_addr !== 15'd0) begin err_cnt++; $display("FAIL rst_wr_addr got %0d want 0", wr_addr); end
        vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL rst_busy got %b want 0", busy); end
        vec_cnt++; if (frame_done !== 1'b0) begin err_cnt++; $display("FAIL rst_frame_done got %b want 0", frame_done); end
        vec_cnt++; if ({err_line, err_frame} !== 2'b00) begin err_cnt++; $display("FAIL rst_errs got %b want 00", {err_line, err_frame}); end
        in_reset = 1'b0; start = 1'b0; vsync = 1'b0; href = 1'b0; px_valid = 1'b0;
        repeat (2) step();
        vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL rst_release_busy got %b want 0", busy); end
    endtask

    task automatic test_nominal();
        int bad;
        clear_mon();
        continuous = 1'b0;
        begin_frame();
        vec_cnt++; if (busy !== 1'b1) begin err_cnt++; $display("FAIL nom_busy got %b want 1", busy); end
        lat_chk = 1'b1;
        for (int l = 0; l < 120; l++) send_line(160);
        lat_chk = 1'b0;
        repeat (4) step();
        bad = 0;
        foreach (wr_q[i]) if (wr_q[i] !== 15'(i)) bad++;
        vec_cnt++; if (wr_q.size() !== 19200) begin err_cnt++; $display("FAIL nom_count got %0d want 19200", wr_q.size()); end
        vec_cnt++; if (bad !== 0) begin err_cnt++; $display("FAIL nom_order got %0d bad addrs want 0", bad); end
        vec_cnt++; if (lat_err !== 0) begin err_cnt++; $display("FAIL nom_latency got %0d bad cycles want 0", lat_err); end
        vec_cnt++; if (fd_cnt !== 1) begin err_cnt++; $display("FAIL nom_frame_done got %0d want 1", fd_cnt); end
        vec_cnt++; if ({err_line, err_frame} !== 2'b00) begin err_cnt++; $display("FAIL nom_errs got %b want 00", {err_line, err_frame}); end
        vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL nom_idle_busy got %b want 0", busy); end
    endtask

    task automatic test_short_long();
        int          len[8] = '{160, 160, 160, 160, 160, 150, 170, 160};
        logic [14:0] exp_q[$];
        int          bad;
        clear_mon();
        begin_frame();
        for (int l = 0; l < 8; l++) begin
            for (int p = 0; p < len[l] && p < 160; p++) exp_q.push_back(15'(l * 160 + p));
            send_line(len[l]);
            if (l == 4) begin
                vec_cnt++; if (err_line !== 1'b0) begin err_cnt++; $display("FAIL sl_exact_lines got err_line=%b want 0", err_line); end
            end
        end
        end_frame_early();
        bad = 0;
        foreach (exp_q[i]) if (i >= wr_q.size() || wr_q[i] !== exp_q[i]) bad++;
        vec_cnt++; if (wr_q.size() !== 1270) begin err_cnt++; $display("FAIL sl_count got %0d want 1270", wr_q.size()); end
        vec_cnt++; if (bad !== 0) begin err_cnt++; $display("FAIL sl_addrs got %0d bad want 0", bad); end
        if (wr_q.size() > 1110) begin
            vec_cnt++; if (wr_q[950] !== 15'd960) begin err_cnt++; $display("FAIL sl_line6_start got %0d want 960", wr_q[950]); end
            vec_cnt++; if (wr_q[1110] !== 15'd1120) begin err_cnt++; $display("FAIL sl_line7_start got %0d want 1120", wr_q[1110]); end
        end else begin
            vec_cnt++; err_cnt++; $display("FAIL sl_short_queue got %0d writes want 1270", wr_q.size());
        end
        vec_cnt++; if (err_line !== 1'b1) begin err_cnt++; $display("FAIL sl_err_line got %b want 1", err_line); end
        vec_cnt++; if (fd_cnt !== 1) begin err_cnt++; $display("FAIL sl_frame_done got %0d want 1", fd_cnt); end
    endtask

    task automatic test_early_vsync();
        clear_mon();
        begin_frame();
        vec_cnt++; if ({err_line, err_frame} !== 2'b00) begin err_cnt++; $display("FAIL ev_start_clears got %b want 00", {err_line, err_frame}); end
        for (int l = 0; l < 60; l++) send_line(160);
        vec_cnt++; if (err_frame !== 1'b0) begin err_cnt++; $display("FAIL ev_before_vsync got err_frame=%b want 0", err_frame); end
        end_frame_early();
        vec_cnt++; if (fd_cnt !== 1) begin err_cnt++; $display("FAIL ev_frame_done got %0d want 1", fd_cnt); end
        vec_cnt++; if (err_frame !== 1'b1) begin err_cnt++; $display("FAIL ev_err_frame got %b want 1", err_frame); end
        vec_cnt++; if (err_line !== 1'b0) begin err_cnt++; $display("FAIL ev_err_line got %b want 0", err_line); end
        vec_cnt++; if (wr_q.size() !== 9600) begin err_cnt++; $display("FAIL ev_count got %0d want 9600", wr_q.size()); end
        vec_cnt++; if (wr_addr !== 15'd9599) begin err_cnt++; $display("FAIL ev_last_addr got %0d want 9599", wr_addr); end
    endtask

    task automatic test_continuous();
        clear_mon();
        continuous = 1'b1;
        start = 1'b1; step(); start = 1'b0;
        busy_chk = 1'b1;
        vsync = 1'b1; repeat (3) step();
        vsync = 1'b0; repeat (2) step();
        for (int l = 0; l < 3; l++) send_line(160);
        end_frame_early();
        vec_cnt++; if (busy !== 1'b1) begin err_cnt++; $display("FAIL cont_rearmed got busy=%b want 1", busy); end
        vsync = 1'b0; repeat (2) step();
        for (int l = 0; l < 3; l++) send_line(160);
        end_frame_early();
        busy_chk = 1'b0;
        vec_cnt++; if (fd_cnt !== 2) begin err_cnt++; $display("FAIL cont_frame_done got %0d want 2", fd_cnt); end
        vec_cnt++; if (wr_q.size() !== 960) begin err_cnt++; $display("FAIL cont_count got %0d want 960", wr_q.size()); end
        if (wr_q.size() > 480) begin
            vec_cnt++; if (wr_q[479] !== 15'd479) begin err_cnt++; $display("FAIL cont_f1_last got %0d want 479", wr_q[479]); end
            vec_cnt++; if (wr_q[480] !== 15'd0) begin err_cnt++; $display("FAIL cont_f2_first got %0d want 0", wr_q[480]); end
        end else begin
            vec_cnt++; err_cnt++; $display("FAIL cont_short_queue got %0d writes want 960", wr_q.size());
        end
        vec_cnt++; if (busy_gap !== 0) begin err_cnt++; $display("FAIL cont_busy_gap got %0d cycles want 0", busy_gap); end
        vec_cnt++; if (busy !== 1'b1) begin err_cnt++; $display("FAIL cont_end_busy got %b want 1", busy); end
        continuous = 1'b0;
    endtask

    task automatic test_reset_mid_frame();
        pulse_reset();
        clear_mon();
        begin_frame();
        for (int l = 0; l < 39; l++) send_line(160);
        send_line(150);
        vec_cnt++; if (err_line !== 1'b1) begin err_cnt++; $display("FAIL rmf_pre_err_line got %b want 1", err_line); end
        href = 1'b1; px_valid = 1'b1;
        repeat (10) step();
        vec_cnt++; if (wr_addr !== 15'd6409) begin err_cnt++; $display("FAIL rmf_pre_addr got %0d want 6409", wr_addr); end
        in_reset = 1'b1; step();
        vec_cnt++; if (wr_en !== 1'b0) begin err_cnt++; $display("FAIL rmf_wr_en got %b want 0", wr_en); end
        vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL rmf_busy got %b want 0", busy); end
        vec_cnt++; if ({err_line, err_frame} !== 2'b00) begin err_cnt++; $display("FAIL rmf_errs got %b want 00", {err_line, err_frame}); end
        in_reset = 1'b0; href = 1'b0; px_valid = 1'b0;
        repeat (2) step();
        clear_mon();
        start = 1'b1; step(); start = 1'b0;
        vsync = 1'b1; href = 1'b1; px_valid = 1'b1;
        repeat (3) step();
        href = 1'b0; px_valid = 1'b0; step();
        vec_cnt++; if (wr_q.size() !== 0) begin err_cnt++; $display("FAIL rmf_armed_writes got %0d want 0", wr_q.size()); end
        vsync = 1'b0; repeat (2) step();
        send_line(160);
        vec_cnt++; if (wr_q.size() !== 160) begin err_cnt++; $display("FAIL rmf_restart_count got %0d want 160", wr_q.size()); end
        if (wr_q.size() == 160) begin
            vec_cnt++; if (wr_q[0] !== 15'd0) begin err_cnt++; $display("FAIL rmf_restart_first got %0d want 0", wr_q[0]); end
            vec_cnt++; if (wr_q[159] !== 15'd159) begin err_cnt++; $display("FAIL rmf_restart_last got %0d want 159", wr_q[159]); end
        end
    endtask

    task automatic test_subsample();
        int  bad;
        bit  exp_wr;
        pulse_reset();
        clear_mon();
        begin_frame();
        bad = 0;
        for (int l = 0; l < 12; l++) begin
            href = 1'b1;
            for (int p = 0; p < 16; p++) begin
                px_valid = 1'b1;
                step();
                exp_wr = (l % 2 == 0) && (p % 2 == 0);
                if (s_wr_en !== exp_wr) bad++;
                else if (exp_wr && (s_wr_addr !== 6'((l / 2) * 8 + p / 2))) bad++;
            end
            px_valid = 1'b0;
            href     = 1'b0;
            repeat (4) step();
        end
        vec_cnt++; if (bad !== 0) begin err_cnt++; $display("FAIL sub_pattern got %0d bad pixels want 0", bad); end
        vec_cnt++; if (s_wr_cnt !== 48) begin err_cnt++; $display("FAIL sub_count got %0d want 48", s_wr_cnt); end
        vec_cnt++; if (s_fd_cnt !== 1) begin err_cnt++; $display("FAIL sub_frame_done got %0d want 1", s_fd_cnt); end
        vec_cnt++; if ({s_err_line, s_err_frame} !== 2'b00) begin err_cnt++; $display("FAIL sub_errs got %b want 00", {s_err_line, s_err_frame}); end
        vec_cnt++; if (s_busy !== 1'b0) begin err_cnt++; $display("FAIL sub_idle_busy got %b want 0", s_busy); end
    endtask

    initial begin
        in_reset = 1'b1; start = 1'b0; continuous = 1'b0;
        vsync = 1'b0; href = 1'b0; px_valid = 1'b0;
        clear_mon();
        test_reset();
        test_nominal();
        test_short_long();
        test_early_vsync();
        test_continuous();
        test_reset_mid_frame();
        test_subsample();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
